// File: rtl/iot_monitor_pkg.sv
// rtl/iot_monitor_pkg.sv - shared constants for the active-IoT-devices monitor and its feeders
package iot_monitor_pkg;

    localparam logic EVT_OFF       = 1'b0;
    localparam logic EVT_ON        = 1'b1;
    localparam int   N_DEV_DEFAULT = 8;
    // Monitor up/down counter width; device count must stay within its range.
    localparam int   MON_CNT_W     = 8;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority arbiter, first request at or above ptr wins
module rr_arbiter #(
    parameter  int N    = 8,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt_vld,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest request to ptr is assigned last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        sum     = '0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(N)) begin
                sum = sum - (ID_W + 1)'(N);
            end
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

endmodule

// File: rtl/device_event_serialiser.sv
// rtl/device_event_serialiser.sv - turns device on/off transitions into one queued event per clock
// EVT_STATS_EN adds the saturating evt_total issued-event counter output.
module device_event_serialiser
    import iot_monitor_pkg::*;
#(
    parameter  int N_DEV = N_DEV_DEFAULT,
    localparam int ID_W  = $clog2(N_DEV),
    localparam int CNT_W = $clog2(N_DEV + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_status,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic [CNT_W-1:0] pending_cnt
`ifdef EVT_STATS_EN
    ,
    output logic [15:0]      evt_total
`endif
);

    logic [N_DEV-1:0] status_q;
    logic [N_DEV-1:0] pend_on;
    logic [N_DEV-1:0] pend_off;
    logic [ID_W-1:0]  rr_ptr;

    logic [N_DEV-1:0] rise;
    logic [N_DEV-1:0] fall;
    logic [N_DEV-1:0] pend_on_n;
    logic [N_DEV-1:0] pend_off_n;
    logic [CNT_W-1:0] cnt_n;
    logic [ID_W-1:0]  rr_ptr_n;
    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_id;
    logic             granted;

    assign rise = dev_status & ~status_q;
    assign fall = ~dev_status & status_q;

    rr_arbiter #(.N(N_DEV)) u_arb (
        .req     (pend_on | pend_off),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    // A new edge on the device being granted this cycle must queue, not cancel:
    // the granted event has already left the queue.
    always_comb begin
        pend_on_n  = pend_on;
        pend_off_n = pend_off;
        cnt_n      = '0;
        granted    = 1'b0;
        if (gnt_vld) begin
            pend_on_n[gnt_id]  = 1'b0;
            pend_off_n[gnt_id] = 1'b0;
        end
        for (int i = 0; i < N_DEV; i++) begin
            granted = gnt_vld && (gnt_id == ID_W'(i));
            if (rise[i]) begin
                if (pend_off[i] && !granted) pend_off_n[i] = 1'b0;
                else                         pend_on_n[i]  = 1'b1;
            end
            if (fall[i]) begin
                if (pend_on[i] && !granted) pend_on_n[i]  = 1'b0;
                else                        pend_off_n[i] = 1'b1;
            end
            cnt_n = cnt_n + CNT_W'(pend_on_n[i] | pend_off_n[i]);
        end
    end

    always_comb begin
        rr_ptr_n = rr_ptr;
        if (gnt_vld) begin
            rr_ptr_n = (gnt_id == ID_W'(N_DEV - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q    <= '0;
            pend_on     <= '0;
            pend_off    <= '0;
            rr_ptr      <= '0;
            change      <= 1'b0;
            on_off      <= EVT_OFF;
            dev_id      <= '0;
            pending_cnt <= '0;
        end else begin
            status_q    <= dev_status;
            pend_on     <= pend_on_n;
            pend_off    <= pend_off_n;
            rr_ptr      <= rr_ptr_n;
            change      <= gnt_vld;
            on_off      <= (gnt_vld && pend_on[gnt_id]) ? EVT_ON : EVT_OFF;
            dev_id      <= gnt_vld ? gnt_id : '0;
            pending_cnt <= cnt_n;
        end
    end

`ifdef EVT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_total <= '0;
        end else if (gnt_vld && evt_total != 16'hFFFF) begin
            evt_total <= evt_total + 16'd1;
        end
    end
`endif

    a_pend_exclusive : assert property (@(posedge clk) disable iff (rst) (pend_on & pend_off) == '0);

endmodule
